// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer for the MEM stage of a 5-stage pipeline.
// Latency: a load/store seen in IDLE launches a registered request on the next
//          edge; the pipeline is held through IDLE-detect plus every BUSY cycle.
// Backpressure: stall freezes PC, IF/ID, ID/EX and EX/MEM until dmem_ack (or the
//          timeout) and wb_bubble masks MEM/WB writes for the same cycles.
//
// Ports:
//   clk, reset                 - pipeline clock, async active-high reset
//   memread_in, memwrite_in    - EX/MEM memory controls
//   addr_in, wdata_in          - EX/MEM byte address and store data
//   dmem_ack, dmem_rdata       - memory completion strobe and read data
//   dmem_req, dmem_we,
//   dmem_addr, dmem_wdata      - registered request bundle to memory
//   stall, wb_bubble           - pipeline hold / MEM/WB bubble
//   read_data_out              - captured load data for MEM/WB
//   timeout_err                - sticky timeout indication

module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CW      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread_in,
  input  logic        memwrite_in,
  input  logic [63:0] addr_in,
  input  logic [63:0] wdata_in,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  output logic        stall,
  output logic        wb_bubble,
  output logic [63:0] read_data_out,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter value on the last BUSY cycle we are willing to wait.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] count;
  logic          acc;
  logic          to_hit;
  logic          stall_raw;

  assign acc    = memread_in | memwrite_in;
  assign to_hit = (TIMEOUT != 0) && (count == TO_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and stall
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    stall_raw = 1'b0;
    case (state)
      IDLE: begin
        stall_raw = acc;
        if (acc) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        stall_raw = 1'b1;
        if (dmem_ack || to_hit) begin
          state_nxt = DONE;
        end
      end
      // The instruction in EX/MEM is the one that just completed, so acc is
      // deliberately not looked at here; a following memory op is seen in IDLE.
      DONE: begin
        stall_raw = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Reset is folded in so the pipeline is not held while reset is asserted,
  // even if EX/MEM happens to present a memory op.
  assign stall     = stall_raw & ~reset;
  assign wb_bubble = stall;

  // ---------------------------------------------------------------------------
  // Request bundle, wait counter, load data capture, timeout flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      read_data_out <= '0;
      count         <= '0;
      timeout_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc) begin
            // Read+write together is treated as a store: we follows memwrite.
            dmem_addr  <= addr_in;
            dmem_wdata <= wdata_in;
            dmem_we    <= memwrite_in;
            dmem_req   <= 1'b1;
            count      <= '0;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            // Ack has priority over a timeout landing on the same cycle.
            read_data_out <= dmem_we ? 64'd0 : dmem_rdata;
            dmem_req      <= 1'b0;
          end else begin
            count <= count + CW'(1);
            if (to_hit) begin
              read_data_out <= '0;
              timeout_err   <= 1'b1;
              dmem_req      <= 1'b0;
            end
          end
        end
        default: begin
          // DONE: nothing to update; request bundle already retired.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: cycle table on the default instance,
// hand sequences for timeout (short-timeout instance) and mid-access reset.
module tb_dmem_access_ctrl;

  logic        clk;
  logic        reset;
  logic        memread_in, memwrite_in;
  logic [63:0] addr_in, wdata_in;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic        stall, wb_bubble;
  logic [63:0] read_data_out;
  logic        timeout_err;

  // Short-timeout instance
  logic        t_rd, t_wr;
  logic [63:0] t_addr, t_wdata;
  logic        t_ack;
  logic [63:0] t_rdata;
  logic        t_req, t_we;
  logic [63:0] t_daddr, t_dwdata;
  logic        t_stall, t_bubble;
  logic [63:0] t_rdo;
  logic        t_terr;

  int checks = 0;
  int errors = 0;

  dmem_access_ctrl u_dut (
    .clk(clk), .reset(reset),
    .memread_in(memread_in), .memwrite_in(memwrite_in),
    .addr_in(addr_in), .wdata_in(wdata_in),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .stall(stall), .wb_bubble(wb_bubble),
    .read_data_out(read_data_out), .timeout_err(timeout_err)
  );

  dmem_access_ctrl #(.TIMEOUT(4), .CW(3)) u_dut_to (
    .clk(clk), .reset(reset),
    .memread_in(t_rd), .memwrite_in(t_wr),
    .addr_in(t_addr), .wdata_in(t_wdata),
    .dmem_ack(t_ack), .dmem_rdata(t_rdata),
    .dmem_req(t_req), .dmem_we(t_we),
    .dmem_addr(t_daddr), .dmem_wdata(t_dwdata),
    .stall(t_stall), .wb_bubble(t_bubble),
    .read_data_out(t_rdo), .timeout_err(t_terr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd, wr;
    logic [63:0] addr, wdata;
    logic        ack;
    logic [63:0] rdata;
    logic        e_req, e_we;
    logic [63:0] e_addr, e_wdata;
    logic        e_stall;
    logic [63:0] e_rdo;
  } vec_t;

  function automatic vec_t v(input logic rd, input logic wr,
                             input logic [63:0] a, input logic [63:0] wd,
                             input logic ack, input logic [63:0] rdt,
                             input logic er, input logic ew,
                             input logic [63:0] ea, input logic [63:0] ewd,
                             input logic es, input logic [63:0] erdo);
    vec_t r;
    r.rd = rd; r.wr = wr; r.addr = a; r.wdata = wd; r.ack = ack; r.rdata = rdt;
    r.e_req = er; r.e_we = ew; r.e_addr = ea; r.e_wdata = ewd;
    r.e_stall = es; r.e_rdo = erdo;
    return r;
  endfunction

  // One access on the short-timeout instance, entered with it in IDLE.
  task automatic t_access(input string name, input logic rd, input logic wr,
                          input logic [63:0] a, input int ack_at,
                          input logic [63:0] rd_data, input int exp_busy,
                          input logic [63:0] exp_rdo, input logic exp_terr);
    int n;
    t_rd = rd; t_wr = wr; t_addr = a; t_wdata = 64'h0; t_ack = 1'b0;
    #1;
    chk({name, "_idle_stall"}, t_stall, 1'b1);
    @(posedge clk); #1;
    n = 0;
    while (t_req && n < 20) begin
      n++;
      if (t_stall !== 1'b1) chk({name, "_busy_stall"}, t_stall, 1'b1);
      t_ack   = (n == ack_at);
      t_rdata = rd_data;
      @(posedge clk); #1;
    end
    t_ack = 1'b0;
    chk({name, "_busy_cycles"}, 64'(n), 64'(exp_busy));
    chk({name, "_done_stall"}, t_stall, 1'b0);
    chk({name, "_rdo"}, t_rdo, exp_rdo);
    chk({name, "_terr"}, t_terr, exp_terr);
    t_rd = 1'b0; t_wr = 1'b0;
    @(posedge clk); #1;
  endtask

  vec_t vt[22];

  initial begin
    vt[0]  = v(1,0,'h100,'h0,  0,'h0,        0,0,'h0,  'h0,  1,'h0);
    vt[1]  = v(1,0,'h100,'h0,  1,'hDEADBEEF, 1,0,'h100,'h0,  1,'h0);
    vt[2]  = v(1,0,'h100,'h0,  0,'h0,        0,0,'h100,'h0,  0,'hDEADBEEF);
    vt[3]  = v(0,1,'h200,'h55, 0,'h0,        0,0,'h100,'h0,  1,'hDEADBEEF);
    vt[4]  = v(0,1,'h200,'h55, 0,'h0,        1,1,'h200,'h55, 1,'hDEADBEEF);
    vt[5]  = v(0,1,'h200,'h55, 0,'h0,        1,1,'h200,'h55, 1,'hDEADBEEF);
    vt[6]  = v(0,1,'h200,'h55, 0,'h0,        1,1,'h200,'h55, 1,'hDEADBEEF);
    vt[7]  = v(0,1,'h200,'h55, 1,'h1234,     1,1,'h200,'h55, 1,'hDEADBEEF);
    vt[8]  = v(0,1,'h200,'h55, 0,'h0,        0,1,'h200,'h55, 0,'h0);
    vt[9]  = v(1,0,'h300,'h0,  0,'h0,        0,1,'h200,'h55, 1,'h0);
    vt[10] = v(1,0,'h300,'h0,  1,'hAAAA,     1,0,'h300,'h0,  1,'h0);
    vt[11] = v(1,0,'h300,'h0,  0,'h0,        0,0,'h300,'h0,  0,'hAAAA);
    vt[12] = v(1,0,'h308,'h0,  0,'h0,        0,0,'h300,'h0,  1,'hAAAA);
    vt[13] = v(1,0,'h308,'h0,  1,'hBBBB,     1,0,'h308,'h0,  1,'hAAAA);
    vt[14] = v(1,0,'h308,'h0,  1,'hCCCC,     0,0,'h308,'h0,  0,'hBBBB);
    vt[15] = v(1,1,'h400,'h77, 0,'h0,        0,0,'h308,'h0,  1,'hBBBB);
    vt[16] = v(1,1,'h400,'h77, 0,'h0,        1,1,'h400,'h77, 1,'hBBBB);
    vt[17] = v(1,1,'h400,'h77, 1,'h9999,     1,1,'h400,'h77, 1,'hBBBB);
    vt[18] = v(1,1,'h400,'h77, 0,'h0,        0,1,'h400,'h77, 0,'h0);
    vt[19] = v(0,0,'h500,'h1,  0,'h0,        0,1,'h400,'h77, 0,'h0);
    vt[20] = v(0,0,'h508,'h2,  1,'hFFFF,     0,1,'h400,'h77, 0,'h0);
    vt[21] = v(0,0,'h510,'h3,  0,'h0,        0,1,'h400,'h77, 0,'h0);

    // Reset with a memory op presented: outputs zero, no stall.
    reset = 1'b1;
    memread_in = 1'b1; memwrite_in = 1'b0; addr_in = 64'h100; wdata_in = 64'h0;
    dmem_ack = 1'b0; dmem_rdata = 64'h0;
    t_rd = 1'b1; t_wr = 1'b0; t_addr = 64'h0; t_wdata = 64'h0;
    t_ack = 1'b0; t_rdata = 64'h0;
    @(negedge clk); @(negedge clk);
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_we", dmem_we, 1'b0);
    chk("rst_addr", dmem_addr, 64'h0);
    chk("rst_wdata", dmem_wdata, 64'h0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_bubble", wb_bubble, 1'b0);
    chk("rst_rdo", read_data_out, 64'h0);
    chk("rst_terr", timeout_err, 1'b0);
    chk("rst_t_stall", t_stall, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    t_rd = 1'b0;

    // Per-cycle vectors: load, store with 3 waits, back-to-back loads,
    // read+write as store, non-memory stream with stray acks.
    for (int i = 0; i < 22; i++) begin
      memread_in  = vt[i].rd;
      memwrite_in = vt[i].wr;
      addr_in     = vt[i].addr;
      wdata_in    = vt[i].wdata;
      dmem_ack    = vt[i].ack;
      dmem_rdata  = vt[i].rdata;
      @(negedge clk);
      chk($sformatf("v%0d_req", i), dmem_req, vt[i].e_req);
      chk($sformatf("v%0d_we", i), dmem_we, vt[i].e_we);
      chk($sformatf("v%0d_addr", i), dmem_addr, vt[i].e_addr);
      chk($sformatf("v%0d_wdata", i), dmem_wdata, vt[i].e_wdata);
      chk($sformatf("v%0d_stall", i), stall, vt[i].e_stall);
      chk($sformatf("v%0d_bubble", i), wb_bubble, vt[i].e_stall);
      chk($sformatf("v%0d_rdo", i), read_data_out, vt[i].e_rdo);
      chk($sformatf("v%0d_terr", i), timeout_err, 1'b0);
      @(posedge clk); #1;
    end
    memread_in = 1'b0; memwrite_in = 1'b0; dmem_ack = 1'b0;

    // Timeout instance (TIMEOUT=4): ack on final count wins, then a real
    // timeout, then the flag stays set across a normal access.
    t_access("to_ack_last", 1'b1, 1'b0, 64'h600, 4, 64'h1111, 4, 64'h1111, 1'b0);
    t_access("to_expire",   1'b1, 1'b0, 64'h608, 0, 64'h0,    4, 64'h0,    1'b1);
    t_access("to_sticky",   1'b1, 1'b0, 64'h610, 1, 64'h2222, 1, 64'h2222, 1'b1);

    // Reset in the middle of BUSY, then a late ack.
    memread_in = 1'b1; addr_in = 64'h700; wdata_in = 64'h0;
    @(posedge clk); #1;
    dmem_ack = 1'b1; dmem_rdata = 64'h5A5A;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("mid_pre_rdo", read_data_out, 64'h5A5A);
    addr_in = 64'h708;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_pre_req", dmem_req, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_req", dmem_req, 1'b0);
    chk("mid_rst_stall", stall, 1'b0);
    chk("mid_rst_bubble", wb_bubble, 1'b0);
    chk("mid_rst_rdo", read_data_out, 64'h0);
    chk("mid_rst_addr", dmem_addr, 64'h0);
    chk("mid_rst_t_terr", t_terr, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0; memread_in = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 64'hBAD;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("late_ack_req", dmem_req, 1'b0);
    chk("late_ack_rdo", read_data_out, 64'h0);
    chk("late_ack_stall", stall, 1'b0);
    memread_in = 1'b1; addr_in = 64'h710;
    #1;
    chk("late_ack_idle_stall", stall, 1'b1);
    @(posedge clk); #1;
    chk("late_ack_relaunch_req", dmem_req, 1'b1);
    chk("late_ack_relaunch_addr", dmem_addr, 64'h710);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences multi-cycle data-memory accesses for the MEM stage of the 5-stage pipeline.
- Launches a request/acknowledge transaction to data memory when the EX/MEM register holds a load or store.
- Freezes the upstream pipeline registers (PC, IF/ID, ID/EX, EX/MEM) until the access completes, and forces bubbles into MEM/WB while stalled.
- Presents captured load data to the MEM/WB register's read-data input.

Parameters:
- TIMEOUT, 255, maximum BUSY cycles to wait for dmem_ack; 0 disables the timeout.
- CW, 8, counter width; must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- memread_in  in  1  EX/MEM MemRead control.
- memwrite_in  in  1  EX/MEM MemWrite control.
- addr_in  in  64  EX/MEM ALU result (byte address).
- wdata_in  in  64  EX/MEM store data.
- dmem_ack  in  1  memory completion strobe, one cycle.
- dmem_rdata  in  64  memory read data, valid when dmem_ack=1.
- dmem_req  out  1  registered request to memory.
- dmem_we  out  1  registered write enable (1=store).
- dmem_addr  out  64  registered latched address.
- dmem_wdata  out  64  registered latched store data.
- stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM.
- wb_bubble  out  1  force MEM/WB Regwrite/Memtoreg to 0 this cycle.
- read_data_out  out  64  registered load data to MEM/WB read_data_in.
- timeout_err  out  1  sticky flag: an access timed out.

Behaviour:
- Reset (async, any time, including mid-access):
  - state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0.
  - read_data_out=0, counter=0, timeout_err=0.
  - stall and wb_bubble evaluate to 0.
  - An in-flight request is abandoned; a late dmem_ack after reset is ignored.
- States are IDLE, BUSY and DONE. The access signal is acc = memread_in | memwrite_in.
- IDLE:
  - stall = acc (combinational).
  - If acc is 1: latch dmem_addr=addr_in, dmem_wdata=wdata_in, dmem_we=memwrite_in; set dmem_req=1; clear counter; go to BUSY.
  - If memread_in and memwrite_in are both 1, the access is treated as a store.
- BUSY:
  - stall=1. dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable.
  - On dmem_ack=1:
    - Load: read_data_out <= dmem_rdata.
    - Store: read_data_out <= 0.
    - Then dmem_req <= 0 and go to DONE.
  - Otherwise counter increments. If TIMEOUT != 0 and counter == TIMEOUT-1 with no ack: read_data_out <= 0, timeout_err <= 1, dmem_req <= 0, go to DONE.
  - dmem_ack and the timeout in the same cycle: ack wins and timeout_err is not set.
- DONE:
  - stall=0 for exactly one cycle. The completed instruction advances into MEM/WB, capturing read_data_out.
  - acc is ignored in this cycle because it refers to the completed instruction.
  - Next state is unconditionally IDLE. A back-to-back memory op arriving next is detected in IDLE.
- wb_bubble = stall in all states. This prevents duplicate or garbage register writes while EX/MEM is held.
- dmem_ack in IDLE or DONE is ignored.
- Latency: with ack in the first BUSY cycle, the pipeline is stalled for 2 cycles (IDLE-detect cycle + BUSY cycle) and released in DONE. Each extra ack wait cycle adds 1.
- Non-memory instructions in IDLE: stall=0, zero overhead.
- timeout_err stays set until reset.

Test Plan:
- Reset asserted mid-BUSY (req=1) -> on the same cycle dmem_req=0, stall=0, read_data_out=0; a subsequent dmem_ack has no effect and state stays IDLE.
- Load, memread_in=1, addr_in=0x100, ack on first BUSY cycle with dmem_rdata=0xDEADBEEF -> dmem_req high 1 cycle with dmem_addr=0x100, dmem_we=0; stall high 2 cycles then low; read_data_out=0xDEADBEEF in DONE; wb_bubble mirrors stall.
- Store, memwrite_in=1, addr_in=0x200, wdata_in=0x55, ack after 3 wait cycles -> dmem_we=1, dmem_wdata=0x55 stable for 4 req cycles; stall 5 cycles; read_data_out=0.
- Back-to-back load then load -> second request launches in the cycle after DONE; no access is skipped or duplicated (exactly 2 req assertions, 2 acks consumed).
- TIMEOUT=4, no ack -> dmem_req drops after 4 BUSY cycles; timeout_err=1 (sticky across later accesses); read_data_out=0; ack together with the final count -> data captured and timeout_err stays 0.
- memread_in=memwrite_in=1 -> dmem_we=1; non-memory instruction stream -> stall never asserts, dmem_req stays 0.
